// File: rtl/fifo_packet_reader.sv
// Read side of a router input-port FIFO: drains one packet at a time (header, size, payload),
// requests a route for each header and forwards flits downstream on a valid/ack handshake.
module fifo_packet_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         fifo_head,
    input  logic [$clog2(DEPTH):0]   fifo_counter,
    output logic                     fifo_pull,
    output logic                     route_req,
    input  logic                     route_ack,
    output logic [WIDTH-1:0]         header,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_av,
    input  logic                     data_ack,
    output logic                     sending,
    output logic                     packet_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_SIZE,
        S_PAYLOAD,
        S_END
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  header_q, header_d;
    logic [WIDTH-1:0]  remaining_q, remaining_d;
    logic              fifoNonEmpty;
    logic              transfer;

    assign fifoNonEmpty = (fifo_counter != '0);
    assign transfer     = data_av & data_ack;
    assign fifo_pull    = transfer;
    assign data_out     = fifo_head;
    assign header       = header_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            header_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        remaining_d = remaining_q;
        route_req   = 1'b0;
        sending     = 1'b0;
        data_av     = 1'b0;
        packet_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifoNonEmpty) begin
                    header_d = fifo_head;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                route_req = 1'b1;
                if (route_ack) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                sending = 1'b1;
                data_av = fifoNonEmpty;
                if (fifoNonEmpty && data_ack) begin
                    state_d = S_SIZE;
                end
            end
            S_SIZE: begin
                sending = 1'b1;
                data_av = fifoNonEmpty;
                if (fifoNonEmpty && data_ack) begin
                    remaining_d = fifo_head;
                    state_d     = (fifo_head == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                sending = 1'b1;
                data_av = fifoNonEmpty;
                if (fifoNonEmpty && data_ack) begin
                    remaining_d = remaining_q - WIDTH'(1);
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                packet_done = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset is synchronous for state, but outputs must read quiet for the whole reset window.
        if (reset) begin
            route_req   = 1'b0;
            sending     = 1'b0;
            data_av     = 1'b0;
            packet_done = 1'b0;
        end
    end

endmodule
